spi_target_regs: RTL and testbench

SPI mode-0 responder with a byte-wide register file. It is the far end of the SPI master pins that bus_sequencer drives: spi_sclk/spi_ncs/spi_mosi come in, and miso goes out. The block serves as the on-chip loopback target for sequencer bring-up and simulation, and as a generic SPI-configured register bank. All SPI inputs are oversampled in the clk_i domain; clk_i must be at least 4x the SCLK frequency.

---
 rtl/spi_target_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 33 +++
 rtl/spi_target_regs.sv | 219 +++++++++++++++++++++
 tb/tb_spi_target_regs.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target register bank.
package spi_target_pkg;

    localparam int CMD_RNW_BIT = 7;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } spi_tgt_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with rise/fall pulses taken from the last stage
// against one extra delay flop.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dly_r;

    // Synchronizer chain plus edge-detect delay flop.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
            dly_r  <= RESET_LEVEL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_i};
            dly_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_r[SYNC_STAGES-1];
    assign rise_o = sync_o & ~dly_r;
    assign fall_o = ~sync_o & dly_r;

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 responder fronting a byte-wide register file; clk_i oversamples
// all SPI pins and must run at least 4x SCLK.
module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter int          REG_ADDR_WIDTH = 4,
    parameter logic [7:0]  RESET_VALUE    = 8'h00,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      nrst_i,
    input  logic                      spi_sclk_i,
    input  logic                      spi_ncs_i,
    input  logic                      spi_mosi_i,
    output logic                      spi_miso_o,
    output logic                      spi_miso_t,
    output logic                      busy_o,
    output logic                      wr_strobe_o,
    output logic [REG_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [7:0]                wr_data_o,
    input  logic [REG_ADDR_WIDTH-1:0] local_addr_i,
    output logic [7:0]                local_data_o
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ONE = {{(REG_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic                      sclk_s, sclk_rise_s, sclk_fall_s;
    logic                      ncs_s, ncs_rise_s, ncs_fall_s;
    logic [SYNC_STAGES-1:0]    mosi_sync_r;
    logic                      mosi_s;

    spi_tgt_state_t            state_r, state_nxt;
    logic [2:0]                bit_cnt_r, bit_cnt_nxt;
    logic [BYTE_W-1:0]         rx_sh_r, rx_nxt, tx_sh_r, tx_nxt;
    logic [REG_ADDR_WIDTH-1:0] addr_r, addr_nxt;
    logic                      miso_r, miso_nxt, miso_t_r, miso_t_nxt;
    logic                      wr_stb_r, wr_stb_nxt;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_r, wr_addr_nxt;
    logic [BYTE_W-1:0]         wr_data_r, wr_data_nxt;
    logic                      reg_we_s;
    logic [BYTE_W-1:0]         regs_r [NUM_REGS];
    logic [BYTE_W-1:0]         local_data_r;
    logic                      busy_r;

    logic [BYTE_W-1:0]         rx_full_s;
    logic [REG_ADDR_WIDTH-1:0] cmd_addr_s;
    logic                      byte_done_s;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sclk_sync (
        .clk_i (clk_i), .nrst_i (nrst_i), .async_i (spi_sclk_i),
        .sync_o (sclk_s), .rise_o (sclk_rise_s), .fall_o (sclk_fall_s)
    );

    // ncs idles high, so its chain resets high to avoid a phantom select.
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_ncs_sync (
        .clk_i (clk_i), .nrst_i (nrst_i), .async_i (spi_ncs_i),
        .sync_o (ncs_s), .rise_o (ncs_rise_s), .fall_o (ncs_fall_s)
    );

    // MOSI synchronizer, same depth as sclk so samples stay aligned.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi_i};
        end
    end

    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign rx_full_s   = {rx_sh_r[BYTE_W-2:0], mosi_s};
    assign cmd_addr_s  = rx_full_s[REG_ADDR_WIDTH-1:0];
    assign byte_done_s = (bit_cnt_r == 3'd7);

    // Frame FSM: next state and next values of all frame registers.
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        rx_nxt      = rx_sh_r;
        tx_nxt      = tx_sh_r;
        addr_nxt    = addr_r;
        miso_nxt    = miso_r;
        miso_t_nxt  = miso_t_r;
        wr_stb_nxt  = 1'b0;
        wr_addr_nxt = wr_addr_r;
        wr_data_nxt = wr_data_r;
        reg_we_s    = 1'b0;
        if (ncs_rise_s) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 3'd0;
            rx_nxt      = 8'h00;
            miso_nxt    = 1'b0;
            miso_t_nxt  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ncs_fall_s) begin
                        state_nxt   = CMD;
                        bit_cnt_nxt = 3'd0;
                        rx_nxt      = 8'h00;
                        miso_nxt    = 1'b0;
                        miso_t_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                CMD: begin
                    if (sclk_rise_s) begin
                        rx_nxt      = rx_full_s;
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                        if (byte_done_s && rx_full_s[CMD_RNW_BIT]) begin
                            state_nxt = READ;
                            tx_nxt    = regs_r[cmd_addr_s];
                            addr_nxt  = cmd_addr_s + ADDR_ONE;
                        end else if (byte_done_s) begin
                            state_nxt = WRITE;
                            addr_nxt  = cmd_addr_s;
                        end else begin
                            state_nxt = CMD;
                        end
                    end else begin
                        state_nxt = CMD;
                    end
                end
                WRITE: begin
                    if (sclk_rise_s) begin
                        rx_nxt      = rx_full_s;
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                        if (byte_done_s) begin
                            reg_we_s    = 1'b1;
                            wr_stb_nxt  = 1'b1;
                            wr_addr_nxt = addr_r;
                            wr_data_nxt = rx_full_s;
                            addr_nxt    = addr_r + ADDR_ONE;
                        end else begin
                            reg_we_s = 1'b0;
                        end
                    end else begin
                        state_nxt = WRITE;
                    end
                end
                READ: begin
                    if (sclk_fall_s) begin
                        miso_nxt = tx_sh_r[BYTE_W-1];
                        tx_nxt   = {tx_sh_r[BYTE_W-2:0], 1'b0};
                    end else if (sclk_rise_s) begin
                        rx_nxt      = rx_full_s;
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                        if (byte_done_s) begin
                            tx_nxt   = regs_r[addr_r];
                            addr_nxt = addr_r + ADDR_ONE;
                        end else begin
                            tx_nxt = tx_sh_r;
                        end
                    end else begin
                        state_nxt = READ;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    miso_t_nxt = 1'b1;
                end
            endcase
        end
    end

    // Frame state and output registers.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            rx_sh_r   <= 8'h00;
            tx_sh_r   <= 8'h00;
            addr_r    <= {REG_ADDR_WIDTH{1'b0}};
            miso_r    <= 1'b0;
            miso_t_r  <= 1'b1;
            wr_stb_r  <= 1'b0;
            wr_addr_r <= {REG_ADDR_WIDTH{1'b0}};
            wr_data_r <= 8'h00;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            rx_sh_r   <= rx_nxt;
            tx_sh_r   <= tx_nxt;
            addr_r    <= addr_nxt;
            miso_r    <= miso_nxt;
            miso_t_r  <= miso_t_nxt;
            wr_stb_r  <= wr_stb_nxt;
            wr_addr_r <= wr_addr_nxt;
            wr_data_r <= wr_data_nxt;
            busy_r    <= ~ncs_s;
        end
    end

    // Register file and registered local read port.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VALUE;
            end
            local_data_r <= RESET_VALUE;
        end else begin
            if (reg_we_s) begin
                regs_r[addr_r] <= rx_full_s;
            end
            local_data_r <= regs_r[local_addr_i];
        end
    end

    assign spi_miso_o   = miso_r;
    assign spi_miso_t   = miso_t_r;
    assign busy_o       = busy_r;
    assign wr_strobe_o  = wr_stb_r;
    assign wr_addr_o    = wr_addr_r;
    assign wr_data_o    = wr_data_r;
    assign local_data_o = local_data_r;

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: 50 MHz clk, 10 MHz SCLK (3 clk low, 2 clk high).
module tb_spi_target_regs;

    logic       clk;
    logic       nrst_i;
    logic       spi_sclk_i, spi_ncs_i, spi_mosi_i;
    logic       spi_miso_o, spi_miso_t, busy_o, wr_strobe_o;
    logic [3:0] wr_addr_o, local_addr_i;
    logic [7:0] wr_data_o, local_data_o;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         stb_cnt   = 0;
    int         base;
    logic [3:0] stb_addr [16];
    logic [7:0] stb_data [16];
    logic [7:0] rxb [4];
    logic [7:0] rd;
    logic       tri_bad;

    spi_target_regs #(.REG_ADDR_WIDTH(4), .RESET_VALUE(8'h00), .SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .nrst_i       (nrst_i),
        .spi_sclk_i   (spi_sclk_i),
        .spi_ncs_i    (spi_ncs_i),
        .spi_mosi_i   (spi_mosi_i),
        .spi_miso_o   (spi_miso_o),
        .spi_miso_t   (spi_miso_t),
        .busy_o       (busy_o),
        .wr_strobe_o  (wr_strobe_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .local_addr_i (local_addr_i),
        .local_data_o (local_data_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Strobe recorder.
    always @(negedge clk) begin
        if (wr_strobe_o === 1'b1) begin
            stb_addr[stb_cnt % 16] = wr_addr_o;
            stb_data[stb_cnt % 16] = wr_data_o;
            stb_cnt = stb_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic spi_start();
        spi_ncs_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi_i = tx[i];
            repeat (3) @(negedge clk);
            spi_sclk_i = 1'b1;
            repeat (2) @(negedge clk);
            rx[i] = spi_miso_o;
            if (spi_miso_t !== 1'b0) tri_bad = 1'b1;
            spi_sclk_i = 1'b0;
        end
    endtask

    task automatic spi_end();
        repeat (3) @(negedge clk);
        spi_ncs_i  = 1'b1;
        spi_mosi_i = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [7:0] b0, b1, b2, b3, input int n);
        logic [7:0] tx [4];
        logic [7:0] r;
        tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
        tri_bad = 1'b0;
        spi_start();
        for (int k = 0; k < n; k++) begin
            spi_bits(tx[k], 8, r);
            rxb[k] = r;
        end
        spi_end();
    endtask

    task automatic local_rd(input logic [3:0] a, output logic [7:0] d);
        local_addr_i = a;
        @(negedge clk);
        d = local_data_o;
    endtask

    initial begin
        nrst_i = 1'b0; spi_sclk_i = 1'b0; spi_ncs_i = 1'b1; spi_mosi_i = 1'b0;
        local_addr_i = 4'd0; tri_bad = 1'b0;
        repeat (5) @(negedge clk);
        nrst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_miso_t", spi_miso_t, 1'b1);
        check("rst_miso", spi_miso_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_strobe", wr_strobe_o, 1'b0);
        check("rst_local", local_data_o, 8'h00);

        // Single write.
        base = stb_cnt;
        spi_frame(8'h03, 8'hA5, 8'h00, 8'h00, 2);
        check("wr1_count", stb_cnt - base, 1);
        check("wr1_addr", stb_addr[base % 16], 4'd3);
        check("wr1_data", stb_data[base % 16], 8'hA5);
        check("wr1_busy_end", busy_o, 1'b0);
        local_rd(4'd3, rd);
        check("wr1_local3", rd, 8'hA5);

        // Burst write wrapping past index 15.
        base = stb_cnt;
        spi_frame(8'h0E, 8'h11, 8'h22, 8'h33, 4);
        check("wrap_count", stb_cnt - base, 3);
        check("wrap_addr0", stb_addr[base % 16], 4'd14);
        check("wrap_data0", stb_data[base % 16], 8'h11);
        check("wrap_addr1", stb_addr[(base + 1) % 16], 4'd15);
        check("wrap_data1", stb_data[(base + 1) % 16], 8'h22);
        check("wrap_addr2", stb_addr[(base + 2) % 16], 4'd0);
        check("wrap_data2", stb_data[(base + 2) % 16], 8'h33);
        local_rd(4'd0, rd);
        check("wrap_local0", rd, 8'h33);

        // Burst read of regs 5/6.
        spi_frame(8'h05, 8'hC3, 8'h3C, 8'h00, 3);
        base = stb_cnt;
        spi_frame(8'h85, 8'h00, 8'h00, 8'h00, 3);
        check("rd_cmd_miso", rxb[0], 8'h00);
        check("rd_byte1", rxb[1], 8'hC3);
        check("rd_byte2", rxb[2], 8'h3C);
        check("rd_no_strobe", stb_cnt - base, 0);
        check("rd_tri_low", tri_bad, 1'b0);
        check("rd_tri_end", spi_miso_t, 1'b1);

        // Aborted write after 5 data bits.
        base = stb_cnt;
        spi_start();
        spi_bits(8'h02, 8, rd);
        spi_bits(8'hFF, 5, rd);
        spi_end();
        check("abort_no_strobe", stb_cnt - base, 0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_tri", spi_miso_t, 1'b1);
        local_rd(4'd2, rd);
        check("abort_reg2", rd, 8'h00);
        base = stb_cnt;
        spi_frame(8'h02, 8'h77, 8'h00, 8'h00, 2);
        check("after_abort_count", stb_cnt - base, 1);
        check("after_abort_addr", stb_addr[base % 16], 4'd2);
        check("after_abort_data", stb_data[base % 16], 8'h77);

        // Command upper address bits are ignored.
        base = stb_cnt;
        spi_frame(8'h74, 8'h5A, 8'h00, 8'h00, 2);
        check("alias_addr", stb_addr[base % 16], 4'd4);
        check("alias_data", stb_data[base % 16], 8'h5A);
        local_rd(4'd4, rd);
        check("alias_reg4", rd, 8'h5A);

        // Reset asserted in the middle of a frame.
        spi_start();
        spi_bits(8'h03, 4, rd);
        check("mid_busy", busy_o, 1'b1);
        nrst_i = 1'b0;
        #1;
        check("mid_rst_tri", spi_miso_t, 1'b1);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_local", local_data_o, 8'h00);
        check("mid_rst_miso", spi_miso_o, 1'b0);
        spi_ncs_i = 1'b1; spi_sclk_i = 1'b0; spi_mosi_i = 1'b0;
        repeat (3) @(negedge clk);
        nrst_i = 1'b1;
        repeat (3) @(negedge clk);
        local_rd(4'd3, rd);
        check("post_rst_reg3", rd, 8'h00);
        local_rd(4'd4, rd);
        check("post_rst_reg4", rd, 8'h00);
        spi_frame(8'h8E, 8'h00, 8'h00, 8'h00, 2);
        check("post_rst_spi_rd14", rxb[1], 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
